opendap_ap_mux: RTL and testbench

OPENDAP_AP_MUX -- requirements
Module: opendap_ap_mux

---
 rtl/opendap_ap_mux.sv | 133 +++++++++++++
 tb/tb_opendap_ap_mux.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/opendap_ap_mux.sv
// ============================================================================
// Module   : opendap_ap_mux
// Purpose  : Routes DP-side AP accesses to one of N_APS access ports.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module opendap_ap_mux #(
  parameter int N_APS          = 4,
  parameter int TIMEOUT_CYCLES = 0,
  parameter bit ABSENT_ERR     = 1'b0
) (
  input  logic                  swclk,
  input  logic                  rst_n,
  input  logic [7:0]            ap_sel,
  input  logic [5:0]            ap_addr,
  input  logic [31:0]           ap_wdata,
  input  logic                  ap_wen,
  input  logic                  ap_ren,
  input  logic                  ap_abort,
  output logic [31:0]           ap_rdata,
  output logic                  ap_rdy,
  output logic                  ap_err,
  output logic [5:0]            dpacc_addr,
  output logic [31:0]           dpacc_wdata,
  output logic [N_APS-1:0]      dpacc_wen,
  output logic [N_APS-1:0]      dpacc_ren,
  output logic [N_APS-1:0]      dpacc_abort,
  input  logic [N_APS-1:0]      dpacc_rdy,
  input  logic [N_APS-1:0]      dpacc_err,
  input  logic [32*N_APS-1:0]   dpacc_rdata
);

  localparam int          c_sel_w    = (N_APS > 1) ? $clog2(N_APS) : 1;
  localparam logic [15:0] c_tmo_last = (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUED = 2'd1,
    S_WAIT   = 2'd2,
    S_ABSENT = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_sel_w-1:0]   r_cur_sel;
  logic [15:0]          r_tmo_cnt;
  logic [31:0]          r_rdata;
  logic                 r_err;

  logic                 w_idle;
  logic                 w_sel_hit;
  logic                 w_fwd;
  logic                 w_cur_rdy;
  logic                 w_tmo;
  logic [31:0]          w_slice [N_APS];

  assign w_idle    = (r_state == S_IDLE);
  assign w_sel_hit = (32'(ap_sel) < 32'(N_APS));
  // Abort wins over a coincident strobe; reset silences every strobe line.
  assign w_fwd     = rst_n & w_idle & ~ap_abort & w_sel_hit;
  assign w_cur_rdy = dpacc_rdy[r_cur_sel];
  assign w_tmo     = (TIMEOUT_CYCLES != 0) && (r_state == S_WAIT) && !w_cur_rdy
                     && (r_tmo_cnt == c_tmo_last);

  generate
    for (genvar i = 0; i < N_APS; i++) begin : g_ap
      assign w_slice[i]     = dpacc_rdata[32*i +: 32];
      assign dpacc_wen[i]   = w_fwd & ap_wen & (ap_sel == 8'(i));
      assign dpacc_ren[i]   = w_fwd & ap_ren & (ap_sel == 8'(i));
      assign dpacc_abort[i] = rst_n & (ap_abort | (w_tmo & (r_cur_sel == c_sel_w'(i))));
    end
  endgenerate

  assign dpacc_addr  = ap_addr;
  assign dpacc_wdata = ap_wdata;
  assign ap_rdy      = w_idle;
  assign ap_rdata    = r_rdata;
  assign ap_err      = r_err;

  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cur_sel <= '0;
      r_tmo_cnt <= 16'd0;
      r_rdata   <= 32'd0;
      r_err     <= 1'b0;
    end else if (ap_abort) begin
      r_state   <= S_IDLE;
      r_tmo_cnt <= 16'd0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ap_wen | ap_ren) begin
            if (w_sel_hit) begin
              r_cur_sel <= ap_sel[c_sel_w-1:0];
              r_state   <= S_ISSUED;
            end else begin
              r_state   <= S_ABSENT;
            end
          end
        end
        // One dead cycle so the previous access's rdy cannot complete this one.
        S_ISSUED: begin
          r_tmo_cnt <= 16'd0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (w_cur_rdy) begin
            r_rdata <= w_slice[r_cur_sel];
            r_err   <= dpacc_err[r_cur_sel];
            r_state <= S_IDLE;
          end else if (w_tmo) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
        end
        S_ABSENT: begin
          r_rdata <= 32'd0;
          r_err   <= ABSENT_ERR;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_opendap_ap_mux.sv
// ============================================================================
// Module   : tb_opendap_ap_mux
// Purpose  : Directed self-checking bench for opendap_ap_mux (4 APs, timeout 8).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_opendap_ap_mux;

  localparam int N = 4;

  logic           swclk;
  logic           rst_n;
  logic [7:0]     ap_sel;
  logic [5:0]     ap_addr;
  logic [31:0]    ap_wdata;
  logic           ap_wen;
  logic           ap_ren;
  logic           ap_abort;
  logic [31:0]    ap_rdata;
  logic           ap_rdy;
  logic           ap_err;
  logic [5:0]     dpacc_addr;
  logic [31:0]    dpacc_wdata;
  logic [N-1:0]   dpacc_wen;
  logic [N-1:0]   dpacc_ren;
  logic [N-1:0]   dpacc_abort;
  logic [N-1:0]   dpacc_rdy;
  logic [N-1:0]   dpacc_err;
  logic [32*N-1:0] dpacc_rdata;

  int n_vec = 0;
  int n_err = 0;

  opendap_ap_mux #(
    .N_APS          (N),
    .TIMEOUT_CYCLES (8),
    .ABSENT_ERR     (1'b1)
  ) dut (
    .swclk       (swclk),
    .rst_n       (rst_n),
    .ap_sel      (ap_sel),
    .ap_addr     (ap_addr),
    .ap_wdata    (ap_wdata),
    .ap_wen      (ap_wen),
    .ap_ren      (ap_ren),
    .ap_abort    (ap_abort),
    .ap_rdata    (ap_rdata),
    .ap_rdy      (ap_rdy),
    .ap_err      (ap_err),
    .dpacc_addr  (dpacc_addr),
    .dpacc_wdata (dpacc_wdata),
    .dpacc_wen   (dpacc_wen),
    .dpacc_ren   (dpacc_ren),
    .dpacc_abort (dpacc_abort),
    .dpacc_rdy   (dpacc_rdy),
    .dpacc_err   (dpacc_err),
    .dpacc_rdata (dpacc_rdata)
  );

  initial begin
    swclk = 1'b0;
    forever #5 swclk = ~swclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge swclk);
    #1;
  endtask

  // Complete read on AP sel with rdy arriving in the second WAIT cycle.
  task automatic do_access(input int sel, input logic [31:0] rd, input logic er, input string tag);
    ap_sel = 8'(sel);
    ap_ren = 1'b1;
    #1 check({tag, "_fwd"}, 32'(dpacc_ren), 32'(1 << sel));
    tick();
    ap_ren = 1'b0;
    tick();
    tick();
    dpacc_rdy[sel]           = 1'b1;
    dpacc_err[sel]           = er;
    dpacc_rdata[32*sel +: 32] = rd;
    tick();
    dpacc_rdy = '0;
    #1;
    check({tag, "_rdy"},   32'(ap_rdy), 32'd1);
    check({tag, "_rdata"}, ap_rdata, rd);
    check({tag, "_err"},   32'(ap_err), 32'(er));
  endtask

  initial begin
    rst_n       = 1'b0;
    ap_sel      = 8'd0;
    ap_addr     = 6'd0;
    ap_wdata    = 32'd0;
    ap_wen      = 1'b1;
    ap_ren      = 1'b0;
    ap_abort    = 1'b1;
    dpacc_rdy   = '0;
    dpacc_err   = '0;
    dpacc_rdata = '0;

    // Reset holds everything quiet even with strobe and abort requested.
    #2;
    check("rst_rdy",   32'(ap_rdy), 32'd1);
    check("rst_rdata", ap_rdata, 32'd0);
    check("rst_err",   32'(ap_err), 32'd0);
    check("rst_wen",   32'(dpacc_wen), 32'd0);
    check("rst_abort", 32'(dpacc_abort), 32'd0);
    tick();
    rst_n    = 1'b1;
    ap_wen   = 1'b0;
    ap_abort = 1'b0;
    tick();

    // Read AP2, stale rdy during ISSUED, rdy 3 cycles after strobe.
    ap_sel   = 8'd2;
    ap_ren   = 1'b1;
    ap_addr  = 6'h0C;
    ap_wdata = 32'h55AA_1234;
    #1;
    check("r2_ren",   32'(dpacc_ren), 32'h4);
    check("r2_wen",   32'(dpacc_wen), 32'h0);
    check("r2_addr",  32'(dpacc_addr), 32'h0C);
    check("r2_wdata", dpacc_wdata, 32'h55AA_1234);
    tick();
    ap_ren    = 1'b0;
    dpacc_rdy = 4'b0100;
    dpacc_rdata[64 +: 32] = 32'hFFFF_0000;
    #1 check("r2_issued_rdy", 32'(ap_rdy), 32'd0);
    tick();
    dpacc_rdy = 4'b0000;
    ap_wen    = 1'b1;
    #1;
    check("r2_wait_ignore", 32'(dpacc_wen), 32'h0);
    check("r2_wait_rdy",    32'(ap_rdy), 32'd0);
    tick();
    ap_wen    = 1'b0;
    dpacc_rdy = 4'b0100;
    dpacc_rdata[64 +: 32] = 32'h1234_5678;
    #1 check("r2_wait2_rdy", 32'(ap_rdy), 32'd0);
    tick();
    dpacc_rdy = 4'b0000;
    #1;
    check("r2_done_rdy",   32'(ap_rdy), 32'd1);
    check("r2_done_rdata", ap_rdata, 32'h1234_5678);
    check("r2_done_err",   32'(ap_err), 32'd0);
    tick();

    // Unimplemented APSEL 7.
    ap_sel = 8'd7;
    ap_wen = 1'b1;
    #1;
    check("abs_wen", 32'(dpacc_wen), 32'h0);
    check("abs_ren", 32'(dpacc_ren), 32'h0);
    tick();
    ap_wen = 1'b0;
    #1 check("abs_busy", 32'(ap_rdy), 32'd0);
    tick();
    #1;
    check("abs_rdy",   32'(ap_rdy), 32'd1);
    check("abs_rdata", ap_rdata, 32'd0);
    check("abs_err",   32'(ap_err), 32'd1);
    tick();

    do_access(3, 32'hCAFE_F00D, 1'b0, "r3");
    tick();

    // AP1 never answers: abort on the 8th WAIT cycle.
    dpacc_rdata[32 +: 32] = 32'hDEAD_BEEF;
    dpacc_err[1] = 1'b1;
    ap_sel = 8'd1;
    ap_ren = 1'b1;
    tick();
    ap_ren = 1'b0;
    tick();
    for (int k = 1; k <= 8; k++) begin
      #1 check($sformatf("tmo_abort_w%0d", k), 32'(dpacc_abort), (k == 8) ? 32'h2 : 32'h0);
      tick();
    end
    #1;
    check("tmo_rdy",   32'(ap_rdy), 32'd1);
    check("tmo_rdata", ap_rdata, 32'd0);
    check("tmo_err",   32'(ap_err), 32'd1);
    dpacc_err[1] = 1'b0;
    tick();
    tick();
    #1 check("tmo_hold_err", 32'(ap_err), 32'd1);
    tick();

    do_access(3, 32'h0BAD_C0DE, 1'b1, "r3e");
    tick();

    // Host abort in WAIT on AP3.
    ap_sel = 8'd3;
    ap_ren = 1'b1;
    tick();
    ap_ren = 1'b0;
    tick();
    ap_abort = 1'b1;
    #1 check("abt_all", 32'(dpacc_abort), 32'hF);
    tick();
    ap_abort = 1'b0;
    #1;
    check("abt_rdy",   32'(ap_rdy), 32'd1);
    check("abt_err",   32'(ap_err), 32'd0);
    check("abt_rdata", ap_rdata, 32'h0BAD_C0DE);
    check("abt_quiet", 32'(dpacc_abort), 32'h0);
    tick();

    // Strobe together with abort in IDLE.
    ap_sel   = 8'd1;
    ap_wen   = 1'b1;
    ap_abort = 1'b1;
    #1;
    check("sa_wen",   32'(dpacc_wen), 32'h0);
    check("sa_abort", 32'(dpacc_abort), 32'hF);
    tick();
    ap_wen   = 1'b0;
    ap_abort = 1'b0;
    #1 check("sa_idle", 32'(ap_rdy), 32'd1);
    tick();

    // Reset during WAIT, then a normal read on AP0.
    ap_sel = 8'd0;
    ap_ren = 1'b1;
    tick();
    ap_ren = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("mrst_rdy",   32'(ap_rdy), 32'd1);
    check("mrst_rdata", ap_rdata, 32'd0);
    check("mrst_abort", 32'(dpacc_abort), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    do_access(0, 32'hA5A5_0F0F, 1'b0, "r0");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
